// File: rtl/rf_pkg.sv
// Shared constants and types for the decode-stage register file.
package rf_pkg;
  localparam int N        = 24;
  localparam int NREG     = 16;
  localparam int AW       = $clog2(NREG);

  localparam int ZERO_IDX = 0;
  localparam int SP_IDX   = 1;
  localparam int CPSR_IDX = NREG - 3;
  localparam int LR_IDX   = NREG - 2;
  localparam int PC_IDX   = NREG - 1;

  localparam logic [N-1:0] SP_RESET = 24'hDE000;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [N-1:0]  word_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking for RAW hazard detection in decode.
module rf_scoreboard #(
  parameter int NREG = 16,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_dst,
  input  logic            flush,
  input  logic            we_a,
  input  logic [AW-1:0]   wa_a,
  input  logic            we_b,
  input  logic [AW-1:0]   wa_b,
  output logic [NREG-1:0] busy_vec,
  output logic [NREG-1:0] clr_pend
);
  logic [NREG-1:0] busy_q, busy_d;

  // Writeback on either port retires the producer of that register.
  always_comb begin
    clr_pend = '0;
    for (int i = 0; i < NREG; i++)
      clr_pend[i] = (we_a && wa_a == AW'(i)) || (we_b && wa_b == AW'(i));
  end

  // Next busy state: clear on writeback, set on issue (set wins), flush beats all.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREG; i++) begin
      if (clr_pend[i]) busy_d[i] = 1'b0;
      if (iss_valid && iss_dst == AW'(i)) busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
    if (flush) busy_d = '0;
  end

  // Busy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec = busy_q;
endmodule

// File: rtl/scoreboard_register_file.sv
// Decode-stage register file: 3 read / 2 write ports, PC update port,
// write-first bypass and a busy scoreboard for RAW hazard detection.
module scoreboard_register_file #(
  parameter int N                = rf_pkg::N,
  parameter int NREG             = rf_pkg::NREG,
  parameter int AW               = $clog2(NREG),
  parameter int SP_IDX           = rf_pkg::SP_IDX,
  parameter int PC_IDX           = NREG - 1,
  parameter logic [N-1:0] SP_RESET = N'(rf_pkg::SP_RESET)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  input  logic [AW-1:0]   ra3,
  output logic [N-1:0]    rd1,
  output logic [N-1:0]    rd2,
  output logic [N-1:0]    rd3,
  input  logic            we_a,
  input  logic [AW-1:0]   wa_a,
  input  logic [N-1:0]    wd_a,
  input  logic            we_b,
  input  logic [AW-1:0]   wa_b,
  input  logic [N-1:0]    wd_b,
  input  logic            pc_we,
  input  logic [N-1:0]    pc_wd,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_dst,
  input  logic            flush,
  output logic            busy1,
  output logic            busy2,
  output logic            busy3,
  output logic [NREG-1:0] busy_vec
);
  import rf_pkg::*;

  logic [NREG-1:0][N-1:0] regs_q, regs_d;
  logic [NREG-1:0]        clr_pend;

  rf_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_valid(iss_valid),
    .iss_dst  (iss_dst),
    .flush    (flush),
    .we_a     (we_a),
    .wa_a     (wa_a),
    .we_b     (we_b),
    .wa_b     (wa_b),
    .busy_vec (busy_vec),
    .clr_pend (clr_pend)
  );

  // Write-first read mux: zero reg, port A, port B, PC port, then array.
  function automatic logic [N-1:0] rd_mux(input logic [AW-1:0] a,
                                          input logic [NREG-1:0][N-1:0] r);
    if (a == '0)                   return '0;
    else if (we_a && wa_a == a)    return wd_a;
    else if (we_b && wa_b == a)    return wd_b;
    else if (pc_we && a == AW'(PC_IDX)) return pc_wd;
    else                           return r[a];
  endfunction

  // Combinational read ports with bypass.
  always_comb begin
    rd1 = rd_mux(ra1, regs_q);
    rd2 = rd_mux(ra2, regs_q);
    rd3 = rd_mux(ra3, regs_q);
  end

  // A producer writing back this cycle is not reported busy.
  always_comb begin
    busy1 = (ra1 != '0) && busy_vec[ra1] && !clr_pend[ra1];
    busy2 = (ra2 != '0) && busy_vec[ra2] && !clr_pend[ra2];
    busy3 = (ra3 != '0) && busy_vec[ra3] && !clr_pend[ra3];
  end

  // Next array state: later assignments take priority (A > B > PC port).
  always_comb begin
    regs_d = regs_q;
    if (pc_we) regs_d[PC_IDX] = pc_wd;
    if (we_b)  regs_d[wa_b]   = wd_b;
    if (we_a)  regs_d[wa_a]   = wd_a;
    regs_d[0] = '0;
  end

  // Storage array; SP comes out of reset at its boot value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q         <= '0;
      regs_q[SP_IDX] <= SP_RESET;
    end else begin
      regs_q <= regs_d;
    end
  end
endmodule

// File: tb/tb_scoreboard_register_file.sv
// Randomized and directed checks of scoreboard_register_file against a
// behavioural model of architectural register and busy state.
module tb_scoreboard_register_file;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ra1, ra2, ra3, wa_a, wa_b, iss_dst;
  logic [23:0] rd1, rd2, rd3, wd_a, wd_b, pc_wd;
  logic        we_a, we_b, pc_we, iss_valid, flush;
  logic        busy1, busy2, busy3;
  logic [15:0] busy_vec;

  int checks = 0;
  int errors = 0;

  logic [23:0] m_reg [16];
  bit          m_busy [16];

  scoreboard_register_file dut (
    .clk(clk), .rst(rst),
    .ra1(ra1), .ra2(ra2), .ra3(ra3),
    .rd1(rd1), .rd2(rd2), .rd3(rd3),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .pc_we(pc_we), .pc_wd(pc_wd),
    .iss_valid(iss_valid), .iss_dst(iss_dst), .flush(flush),
    .busy1(busy1), .busy2(busy2), .busy3(busy3), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_reg[i]  = 24'h0;
      m_busy[i] = 1'b0;
    end
    m_reg[1] = 24'hDE000;
  endfunction

  function automatic logic [23:0] model_read(input logic [3:0] a);
    if (a == 0) return 24'h0;
    if (we_a && wa_a == a) return wd_a;
    if (we_b && wa_b == a) return wd_b;
    if (pc_we && a == 4'd15) return pc_wd;
    return m_reg[a];
  endfunction

  function automatic bit model_busy(input logic [3:0] a);
    bit written;
    written = (we_a && wa_a == a) || (we_b && wa_b == a);
    return (a != 0) && m_busy[a] && !written;
  endfunction

  function automatic logic [15:0] model_busy_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // One clock edge worth of architectural effect, from the rules:
  // for each register pick its single winning writer; busy per register.
  function automatic void model_commit();
    logic [23:0] nr [16];
    bit          nb [16];
    for (int i = 0; i < 16; i++) begin
      nr[i] = m_reg[i];
      if (i != 0) begin
        if (we_a && wa_a == i)       nr[i] = wd_a;
        else if (we_b && wa_b == i)  nr[i] = wd_b;
        else if (pc_we && i == 15)   nr[i] = pc_wd;
      end
      if (flush)                             nb[i] = 1'b0;
      else if (i == 0)                       nb[i] = 1'b0;
      else if (iss_valid && iss_dst == i)    nb[i] = 1'b1;
      else if ((we_a && wa_a == i) || (we_b && wa_b == i)) nb[i] = 1'b0;
      else                                   nb[i] = m_busy[i];
    end
    for (int i = 0; i < 16; i++) begin
      m_reg[i]  = nr[i];
      m_busy[i] = nb[i];
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    we_a = 0; wa_a = 0; wd_a = 0;
    we_b = 0; wa_b = 0; wd_b = 0;
    pc_we = 0; pc_wd = 0;
    iss_valid = 0; iss_dst = 0; flush = 0;
  endtask

  // Advance one clock; inputs are held from the previous negedge.
  task automatic step();
    @(posedge clk);
    if (!rst) model_commit();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    we_a = 1; wa_a = 4; wd_a = 24'h000055;
    iss_valid = 1; iss_dst = 9;
    step();
    idle();
    rst = 1;
    model_reset();
    ra1 = 1; ra2 = 4; ra3 = 9;
    #1;
    checks++;
    if (rd1 !== 24'hDE000) begin errors++; $display("FAIL reset_sp got %h want %h", rd1, 24'hDE000); end
    checks++;
    if (rd2 !== 24'h0) begin errors++; $display("FAIL reset_r4 got %h want %h", rd2, 24'h0); end
    checks++;
    if (busy_vec !== 16'h0) begin errors++; $display("FAIL reset_busy_vec got %h want %h", busy_vec, 16'h0); end
    checks++;
    if (busy3 !== 1'b0) begin errors++; $display("FAIL reset_busy3 got %b want 0", busy3); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_dual_write();
    idle();
    we_a = 1; wa_a = 5; wd_a = 24'h111111;
    we_b = 1; wa_b = 5; wd_b = 24'h222222;
    ra1 = 5;
    #1;
    checks++;
    if (rd1 !== 24'h111111) begin errors++; $display("FAIL dual_bypass got %h want %h", rd1, 24'h111111); end
    step();
    idle();
    ra1 = 5;
    #1;
    checks++;
    if (rd1 !== 24'h111111) begin errors++; $display("FAIL dual_stored got %h want %h", rd1, 24'h111111); end
  endtask

  task automatic test_bypass_zero();
    idle();
    we_a = 1; wa_a = 7; wd_a = 24'hABCDEF; ra1 = 7;
    #1;
    checks++;
    if (rd1 !== 24'hABCDEF) begin errors++; $display("FAIL bypass_r7 got %h want %h", rd1, 24'hABCDEF); end
    step();
    idle();
    we_a = 1; wa_a = 0; wd_a = 24'h123456; ra2 = 0;
    iss_valid = 1; iss_dst = 0;
    #1;
    checks++;
    if (rd2 !== 24'h0) begin errors++; $display("FAIL zero_bypass got %h want %h", rd2, 24'h0); end
    step();
    idle();
    ra1 = 7; ra2 = 0;
    #1;
    checks++;
    if (rd2 !== 24'h0) begin errors++; $display("FAIL zero_stored got %h want %h", rd2, 24'h0); end
    checks++;
    if (busy_vec[0] !== 1'b0) begin errors++; $display("FAIL zero_busy got %b want 0", busy_vec[0]); end
    checks++;
    if (rd1 !== 24'hABCDEF) begin errors++; $display("FAIL r7_stored got %h want %h", rd1, 24'hABCDEF); end
  endtask

  task automatic test_pc();
    idle();
    pc_we = 1; pc_wd = 24'h000108;
    step();
    idle();
    ra1 = 15;
    #1;
    checks++;
    if (rd1 !== 24'h000108) begin errors++; $display("FAIL pc_update got %h want %h", rd1, 24'h000108); end
    pc_we = 1; pc_wd = 24'h000200;
    we_b = 1; wa_b = 15; wd_b = 24'h000400;
    #1;
    checks++;
    if (rd1 !== 24'h000400) begin errors++; $display("FAIL pc_prio_bypass got %h want %h", rd1, 24'h000400); end
    step();
    idle();
    ra1 = 15;
    #1;
    checks++;
    if (rd1 !== 24'h000400) begin errors++; $display("FAIL pc_prio_stored got %h want %h", rd1, 24'h000400); end
  endtask

  task automatic test_scoreboard();
    idle();
    iss_valid = 1; iss_dst = 6;
    step();
    idle();
    ra2 = 6;
    #1;
    checks++;
    if (busy2 !== 1'b1) begin errors++; $display("FAIL sb_set got %b want 1", busy2); end
    we_b = 1; wa_b = 6; wd_b = 24'h000066;
    #1;
    checks++;
    if (busy2 !== 1'b0) begin errors++; $display("FAIL sb_wb_same_cycle got %b want 0", busy2); end
    checks++;
    if (rd2 !== 24'h000066) begin errors++; $display("FAIL sb_wb_data got %h want %h", rd2, 24'h000066); end
    step();
    idle();
    #1;
    checks++;
    if (busy_vec[6] !== 1'b0) begin errors++; $display("FAIL sb_cleared got %b want 0", busy_vec[6]); end
    iss_valid = 1; iss_dst = 6;
    we_a = 1; wa_a = 6; wd_a = 24'h000077;
    step();
    idle();
    #1;
    checks++;
    if (busy_vec[6] !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %b want 1", busy_vec[6]); end
    // A-over-B collision still retires the producer
    we_a = 1; wa_a = 6; wd_a = 24'h1; we_b = 1; wa_b = 6; wd_b = 24'h2;
    step();
    idle();
    #1;
    checks++;
    if (busy_vec[6] !== 1'b0) begin errors++; $display("FAIL sb_collide_clear got %b want 0", busy_vec[6]); end
  endtask

  task automatic test_flush();
    idle();
    iss_valid = 1; iss_dst = 4;
    step();
    iss_dst = 9;
    step();
    idle();
    #1;
    checks++;
    if (busy_vec !== 16'h0210) begin errors++; $display("FAIL flush_pre got %h want %h", busy_vec, 16'h0210); end
    iss_valid = 1; iss_dst = 10; flush = 1;
    step();
    idle();
    #1;
    checks++;
    if (busy_vec !== 16'h0) begin errors++; $display("FAIL flush got %h want %h", busy_vec, 16'h0); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      ra1 = 4'($urandom_range(0, 15));
      ra2 = 4'($urandom_range(0, 15));
      ra3 = 4'($urandom_range(0, 15));
      we_a = ($urandom_range(0, 2) == 0);
      wa_a = 4'($urandom_range(0, 15));
      wd_a = 24'($urandom);
      we_b = ($urandom_range(0, 2) == 0);
      wa_b = ($urandom_range(0, 3) == 0) ? wa_a : 4'($urandom_range(0, 15));
      wd_b = 24'($urandom);
      pc_we = ($urandom_range(0, 3) == 0);
      pc_wd = 24'($urandom);
      iss_valid = ($urandom_range(0, 1) == 0);
      iss_dst = 4'($urandom_range(0, 15));
      flush = ($urandom_range(0, 24) == 0);
      #1;
      checks++;
      if (rd1 !== model_read(ra1)) begin errors++; $display("FAIL rnd_rd1 cyc %0d a %0d got %h want %h", c, ra1, rd1, model_read(ra1)); end
      checks++;
      if (rd2 !== model_read(ra2)) begin errors++; $display("FAIL rnd_rd2 cyc %0d a %0d got %h want %h", c, ra2, rd2, model_read(ra2)); end
      checks++;
      if (rd3 !== model_read(ra3)) begin errors++; $display("FAIL rnd_rd3 cyc %0d a %0d got %h want %h", c, ra3, rd3, model_read(ra3)); end
      checks++;
      if ({busy1, busy2, busy3} !== {model_busy(ra1), model_busy(ra2), model_busy(ra3)}) begin
        errors++;
        $display("FAIL rnd_busy cyc %0d got %b%b%b want %b%b%b", c, busy1, busy2, busy3,
                 model_busy(ra1), model_busy(ra2), model_busy(ra3));
      end
      checks++;
      if (busy_vec !== model_busy_vec()) begin errors++; $display("FAIL rnd_busy_vec cyc %0d got %h want %h", c, busy_vec, model_busy_vec()); end
      step();
    end
    idle();
  endtask

  initial begin
    rst = 1;
    ra1 = 0; ra2 = 0; ra3 = 0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    test_reset();
    test_dual_write();
    test_bypass_zero();
    test_pc();
    test_scoreboard();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
